estufa_planta: RTL and testbench
================================

Name: estufa_planta

Overview:
- Sequential plant model of the greenhouse: consumes the heater/cooler commands produced by the greenhouse controller and generates the two threshold-sensor bits that the controller reads.
- Closes the loop on the board. `sens` wires to the controller's SWI[7:6]; `aquecedor`/`resfriador` come from the controller's LED[6]/LED[7].
- Maintains an internal temperature register that moves one step per prescaled tick, according to the actuator commands and ambient drift.

Parameters:
- NBITS_TEMP, 8, width of the temperature register.
- TEMP_INI, 25, temperature loaded at reset.
- AMBIENTE, 25, temperature the plant drifts toward when idle.
- T_BAIXO, 20, low threshold; `sens[1]` = temp >= T_BAIXO.
- T_ALTO, 30, high threshold; `sens[0]` = temp >= T_ALTO.
- TICK_DIV, 4, clk_2 cycles per temperature tick (>= 1).
- DRIFT_DIV, 2, ticks per ambient-drift step (>= 1).

Ports:
- clk_2 in 1 system clock.
- reset_n in 1 asynchronous, active-low reset.
- carga in 1 synchronous load of temp_in (test/initial condition).
- temp_in in NBITS_TEMP value loaded when carga=1.
- aquecedor in 1 heater command (controller LED[6]).
- resfriador in 1 cooler command (controller LED[7]).
- temp out NBITS_TEMP current temperature, unsigned.
- sens out 2 {ge_baixo, ge_alto}; drives controller SWI[7:6].
- tick out 1 one-cycle pulse on each temperature tick.
- conflito out 1 one-cycle pulse on a tick where both actuators are on.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - temp=TEMP_INI; sens computed from TEMP_INI (defaults: 2'b10).
  - tick=0, conflito=0; prescaler=0, drift counter=0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - The cycle it is at TICK_DIV-1 is a tick cycle: tick=1 is registered on the following edge, aligned with the temperature update.
- Priority on each clk_2 rising edge:
  1. carga=1: temp<=temp_in; prescaler and drift counter cleared; tick=0, conflito=0.
  2. Tick cycle, aquecedor=1 and resfriador=0: temp<=temp+1, saturating at 2^NBITS_TEMP-1. Drift counter cleared.
  3. Tick cycle, resfriador=1 and aquecedor=0: temp<=temp-1, saturating at 0. Drift counter cleared.
  4. Tick cycle, both on: temp held; conflito=1 for that cycle; drift counter cleared.
  5. Tick cycle, neither on: drift counter increments. When it reaches DRIFT_DIV-1 it wraps to 0 and temp moves 1 toward AMBIENTE (unchanged if equal).
  6. Non-tick cycle: temp held; tick=0; conflito=0.
- Latency and sensor alignment:
  - sens is registered. It is computed from the next-state temperature on the same edge that updates temp, so sens always matches temp (zero skew).
  - Actuator change to first temp change: at most TICK_DIV cycles.
- Sensor codes, with normal thresholds (T_BAIXO < T_ALTO):
  - 00 cold.
  - 10 normal.
  - 11 hot.
  - 01 never produced by the plant itself.
- Boundaries:
  - Saturation at 0 and at max: temp holds; tick still pulses.
  - TICK_DIV=1: every cycle is a tick.
  - carga on a tick cycle: the load wins and no step is applied.
  - reset_n asserted mid-tick: immediate return to reset state.
- Inputs are assumed synchronous to clk_2; no internal synchronizers.

Optional Feature:
- Macro: ESTUFA_FALHA_SENSOR_EN.
- When defined:
  - Adds input port `falha_alto` (1 bit).
  - While falha_alto=1, registered sens[0] is forced to 1 (stuck-at-1 high sensor), independent of temp.
  - With temp below T_BAIXO this yields 01, exercising the controller's inconsistency output.
  - temp and all other behaviour are unaffected.
- When undefined: the port is absent and sens[0] is purely threshold-derived.

Test Plan:
- Reset: reset_n=0 then 1, inputs idle -> temp=25, sens=2'b10, tick=0, conflito=0.
- Heating: carga with temp_in=28, then aquecedor=1 for 12 cycles (TICK_DIV=4) -> temp 29,30,31 on successive ticks. sens becomes 2'b11 on the same edge temp reaches 30.
- Cooling with floor saturation: carga temp_in=1, resfriador=1 for 12 cycles -> temp 0, then holds at 0. sens=2'b00. tick keeps pulsing every 4 cycles.
- Conflict: temp=22, both actuators=1 for 8 cycles -> temp stays 22. conflito pulses exactly on the 2 tick cycles.
- Drift: carga temp_in=27, actuators off, DRIFT_DIV=2 -> temp 26 after 8 cycles, 25 after 16, then holds at 25.
- With ESTUFA_FALHA_SENSOR_EN: carga temp_in=15, falha_alto=1 -> sens=2'b01 from the next edge. falha_alto=0 -> sens=2'b00.

Source files
------------

// File: rtl/estufa_planta.sv
// Greenhouse plant model: integrates heater/cooler commands into a temperature
// register and produces the two threshold sensor bits read by the controller.
// Optional macro ESTUFA_FALHA_SENSOR_EN adds falha_alto (high sensor stuck-at-1).
module estufa_planta #(
  parameter int NBITS_TEMP = 8,
  parameter int TEMP_INI   = 25,
  parameter int AMBIENTE   = 25,
  parameter int T_BAIXO    = 20,
  parameter int T_ALTO     = 30,
  parameter int TICK_DIV   = 4,
  parameter int DRIFT_DIV  = 2
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic                  carga,
  input  logic [NBITS_TEMP-1:0] temp_in,
  input  logic                  aquecedor,
  input  logic                  resfriador,
`ifdef ESTUFA_FALHA_SENSOR_EN
  input  logic                  falha_alto,
`endif
  output logic [NBITS_TEMP-1:0] temp,
  output logic [1:0]            sens,
  output logic                  tick,
  output logic                  conflito
);

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;

  localparam logic [PW-1:0]         PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]         DRIFT_LAST = DW'(DRIFT_DIV - 1);
  localparam logic [NBITS_TEMP-1:0] T_MAX      = '1;
  localparam logic [NBITS_TEMP-1:0] T_INI_V    = NBITS_TEMP'(TEMP_INI);
  localparam logic [NBITS_TEMP-1:0] AMB_V      = NBITS_TEMP'(AMBIENTE);
  localparam logic [NBITS_TEMP-1:0] T_BAIXO_V  = NBITS_TEMP'(T_BAIXO);
  localparam logic [NBITS_TEMP-1:0] T_ALTO_V   = NBITS_TEMP'(T_ALTO);
  localparam logic [1:0]            SENS_INI   = {T_INI_V >= T_BAIXO_V, T_INI_V >= T_ALTO_V};

  logic [PW-1:0]         pre, pre_nxt;
  logic [DW-1:0]         drift, drift_nxt;
  logic [NBITS_TEMP-1:0] temp_nxt;
  logic [1:0]            sens_nxt;
  logic                  tick_nxt, confl_nxt;

  always_comb begin
    temp_nxt  = temp;
    pre_nxt   = pre;
    drift_nxt = drift;
    tick_nxt  = 1'b0;
    confl_nxt = 1'b0;
    if (carga) begin
      temp_nxt  = temp_in;
      pre_nxt   = '0;
      drift_nxt = '0;
    end else if (pre == PRE_LAST) begin
      pre_nxt  = '0;
      tick_nxt = 1'b1;
      if (aquecedor && !resfriador) begin
        drift_nxt = '0;
        if (temp != T_MAX) temp_nxt = temp + 1'b1;
      end else if (resfriador && !aquecedor) begin
        drift_nxt = '0;
        if (temp != '0) temp_nxt = temp - 1'b1;
      end else if (aquecedor && resfriador) begin
        drift_nxt = '0;
        confl_nxt = 1'b1;
      end else if (drift == DRIFT_LAST) begin
        // Idle long enough: take one step toward ambient.
        drift_nxt = '0;
        if (temp < AMB_V)      temp_nxt = temp + 1'b1;
        else if (temp > AMB_V) temp_nxt = temp - 1'b1;
      end else begin
        drift_nxt = drift + 1'b1;
      end
    end else begin
      pre_nxt = pre + 1'b1;
    end

    // Sensors follow the next-state temperature so they never lag temp.
    sens_nxt = {temp_nxt >= T_BAIXO_V, temp_nxt >= T_ALTO_V};
`ifdef ESTUFA_FALHA_SENSOR_EN
    if (falha_alto) sens_nxt[0] = 1'b1;
`endif
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      temp     <= T_INI_V;
      sens     <= SENS_INI;
      tick     <= 1'b0;
      conflito <= 1'b0;
      pre      <= '0;
      drift    <= '0;
    end else begin
      temp     <= temp_nxt;
      sens     <= sens_nxt;
      tick     <= tick_nxt;
      conflito <= confl_nxt;
      pre      <= pre_nxt;
      drift    <= drift_nxt;
    end
  end

endmodule

// File: tb/tb_estufa_planta.sv
// Directed testbench for estufa_planta with default parameters
// (TICK_DIV=4, DRIFT_DIV=2, thresholds 20/30, ambient 25).
module tb_estufa_planta;

  logic       clk_2;
  logic       reset_n;
  logic       carga;
  logic [7:0] temp_in;
  logic       aquecedor;
  logic       resfriador;
`ifdef ESTUFA_FALHA_SENSOR_EN
  logic       falha_alto;
`endif
  logic [7:0] temp;
  logic [1:0] sens;
  logic       tick;
  logic       conflito;

  int n_checks = 0;
  int n_errors = 0;

  estufa_planta dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .carga      (carga),
    .temp_in    (temp_in),
    .aquecedor  (aquecedor),
    .resfriador (resfriador),
`ifdef ESTUFA_FALHA_SENSOR_EN
    .falha_alto (falha_alto),
`endif
    .temp       (temp),
    .sens       (sens),
    .tick       (tick),
    .conflito   (conflito)
  );

  // Clock / reset
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cycle();
    @(posedge clk_2);
    #1;
  endtask

  function automatic logic [1:0] sens_of(input int t);
    return {t >= 20, t >= 30};
  endfunction

  task automatic load(input logic [7:0] v);
    carga = 1'b1; temp_in = v;
    cycle();
    carga = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (temp !== 8'd25) begin n_errors++; $display("FAIL reset_temp got %0d exp 25", temp); end
    n_checks++;
    if (sens !== 2'b10) begin n_errors++; $display("FAIL reset_sens got %b exp 10", sens); end
    n_checks++;
    if (tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick got %b exp 0", tick); end
    n_checks++;
    if (conflito !== 1'b0) begin n_errors++; $display("FAIL reset_conflito got %b exp 0", conflito); end
  endtask

  task automatic test_heating();
    int et;
    load(8'd28);
    n_checks++;
    if (temp !== 8'd28) begin n_errors++; $display("FAIL heat_load got %0d exp 28", temp); end
    aquecedor = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      et = 28 + k / 4;
      n_checks++;
      if (temp !== 8'(et)) begin n_errors++; $display("FAIL heat_temp k=%0d got %0d exp %0d", k, temp, et); end
      n_checks++;
      if (sens !== sens_of(et)) begin n_errors++; $display("FAIL heat_sens k=%0d got %b exp %b", k, sens, sens_of(et)); end
      n_checks++;
      if (tick !== (k % 4 == 0)) begin n_errors++; $display("FAIL heat_tick k=%0d got %b exp %b", k, tick, (k % 4 == 0)); end
    end
    aquecedor = 1'b0;
  endtask

  task automatic test_cooling();
    int et;
    load(8'd1);
    resfriador = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      et = (k >= 4) ? 0 : 1;
      n_checks++;
      if (temp !== 8'(et)) begin n_errors++; $display("FAIL cool_temp k=%0d got %0d exp %0d", k, temp, et); end
      n_checks++;
      if (sens !== 2'b00) begin n_errors++; $display("FAIL cool_sens k=%0d got %b exp 00", k, sens); end
      n_checks++;
      if (tick !== (k % 4 == 0)) begin n_errors++; $display("FAIL cool_tick k=%0d got %b exp %b", k, tick, (k % 4 == 0)); end
    end
    resfriador = 1'b0;
  endtask

  task automatic test_conflict();
    load(8'd22);
    aquecedor = 1'b1; resfriador = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      n_checks++;
      if (temp !== 8'd22) begin n_errors++; $display("FAIL confl_temp k=%0d got %0d exp 22", k, temp); end
      n_checks++;
      if (conflito !== (k % 4 == 0)) begin n_errors++; $display("FAIL confl_pulse k=%0d got %b exp %b", k, conflito, (k % 4 == 0)); end
    end
    aquecedor = 1'b0; resfriador = 1'b0;
  endtask

  task automatic test_drift();
    int et;
    load(8'd27);
    for (int k = 1; k <= 24; k++) begin
      cycle();
      et = 27 - (k / 4) / 2;
      if (et < 25) et = 25;
      n_checks++;
      if (temp !== 8'(et)) begin n_errors++; $display("FAIL drift_temp k=%0d got %0d exp %0d", k, temp, et); end
    end
    // Drift from below: 23 -> 24 after two ticks.
    load(8'd23);
    repeat (8) cycle();
    n_checks++;
    if (temp !== 8'd24) begin n_errors++; $display("FAIL drift_up got %0d exp 24", temp); end
  endtask

  task automatic test_load_on_tick();
    load(8'd50);
    aquecedor = 1'b1;
    repeat (3) cycle();
    carga = 1'b1; temp_in = 8'd40;
    cycle();
    carga = 1'b0;
    n_checks++;
    if (temp !== 8'd40) begin n_errors++; $display("FAIL load_tick_temp got %0d exp 40", temp); end
    n_checks++;
    if (tick !== 1'b0) begin n_errors++; $display("FAIL load_tick_tick got %b exp 0", tick); end
    repeat (4) cycle();
    n_checks++;
    if (temp !== 8'd41) begin n_errors++; $display("FAIL load_tick_next got %0d exp 41", temp); end
    aquecedor = 1'b0;
  endtask

  task automatic test_saturate_max();
    load(8'd255);
    aquecedor = 1'b1;
    repeat (4) cycle();
    n_checks++;
    if (temp !== 8'd255) begin n_errors++; $display("FAIL sat_max_temp got %0d exp 255", temp); end
    n_checks++;
    if (tick !== 1'b1) begin n_errors++; $display("FAIL sat_max_tick got %b exp 1", tick); end
    n_checks++;
    if (sens !== 2'b11) begin n_errors++; $display("FAIL sat_max_sens got %b exp 11", sens); end
    aquecedor = 1'b0;
  endtask

  task automatic test_reset_mid_tick();
    load(8'd100);
    aquecedor = 1'b1;
    repeat (4) cycle();
    n_checks++;
    if (temp !== 8'd101) begin n_errors++; $display("FAIL rst_mid_pre got %0d exp 101", temp); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (temp !== 8'd25) begin n_errors++; $display("FAIL rst_mid_temp got %0d exp 25", temp); end
    n_checks++;
    if (tick !== 1'b0) begin n_errors++; $display("FAIL rst_mid_tick got %b exp 0", tick); end
    n_checks++;
    if (sens !== 2'b10) begin n_errors++; $display("FAIL rst_mid_sens got %b exp 10", sens); end
    aquecedor = 1'b0;
    cycle();
    reset_n = 1'b1;
    // Prescaler restarted from 0: first tick exactly 4 cycles later.
    repeat (3) cycle();
    n_checks++;
    if (tick !== 1'b0) begin n_errors++; $display("FAIL rst_mid_pre3 got %b exp 0", tick); end
    cycle();
    n_checks++;
    if (tick !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre4 got %b exp 1", tick); end
  endtask

`ifdef ESTUFA_FALHA_SENSOR_EN
  task automatic test_falha();
    falha_alto = 1'b1;
    load(8'd15);
    n_checks++;
    if (sens !== 2'b01) begin n_errors++; $display("FAIL falha_on got %b exp 01", sens); end
    n_checks++;
    if (temp !== 8'd15) begin n_errors++; $display("FAIL falha_temp got %0d exp 15", temp); end
    falha_alto = 1'b0;
    cycle();
    n_checks++;
    if (sens !== 2'b00) begin n_errors++; $display("FAIL falha_off got %b exp 00", sens); end
  endtask
`endif

  initial begin
    reset_n = 1'b0; carga = 1'b0; temp_in = '0;
    aquecedor = 1'b0; resfriador = 1'b0;
`ifdef ESTUFA_FALHA_SENSOR_EN
    falha_alto = 1'b0;
`endif
    repeat (2) cycle();
    reset_n = 1'b1;
    test_reset();
    cycle();
    test_heating();
    test_cooling();
    test_conflict();
    test_drift();
    test_load_on_tick();
    test_saturate_max();
    test_reset_mid_tick();
`ifdef ESTUFA_FALHA_SENSOR_EN
    test_falha();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
